dot_int_acc: RTL and testbench
==============================

Name: dot_int_acc

Overview:
- Sequential, pipelined successor to the combinational integer dot-product block.
- Computes the dot product of two length-k integer vectors streamed in `lanes` elements per beat over k/lanes beats.
- Accumulates partial sums internally and presents one result per vector through a valid/ready handshake.
- Supports signed or unsigned operands per vector.
- Sits between the MX operand buffers and the block-scaling/accumulation stage, so the multiplier count is `lanes` rather than k.

Parameters:
- bit_width, 8, operand element width.
- k, 32, vector length; must be a multiple of lanes.
- lanes, 8, elements consumed per beat; must satisfy 1 <= lanes <= k.
- prd_width, 2*bit_width+1, per-lane product width; the +1 covers unsigned mode.
- out_width, prd_width+$clog2(k), signed result width.
- beats (localparam), k/lanes, beats per vector.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  upstream beat valid.
- o_ready  output  1  block can accept a beat.
- i_unsigned  input  1  operand mode; sampled on the first beat of each vector only.
- i_vec_a  input  bit_width x lanes  operand A lanes, element 0 first in vector order.
- i_vec_b  input  bit_width x lanes  operand B lanes.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_dp  output  out_width signed  dot-product result.

Behaviour:
- Reset (async assert, sync deassert by i_clk): o_valid=0, o_dp=0, beat counter=0, all stage valids=0, accumulator=0.
- o_ready=1 while i_rst is asserted and after reset.
- Beat accept: i_valid && o_ready at a rising edge.
- Beat counter runs 0..beats-1, increments per accepted beat, and wraps to 0 after beats-1.
- first = (count==0); last = (count==beats-1); for beats==1 both are true every beat.
- Mode register: loaded from i_unsigned when first; held for the rest of the vector. i_unsigned on later beats is ignored. When beats==1 the mode is taken from the beat itself.
- Operand extension: unsigned mode zero-extends to bit_width+1; signed mode sign-extends to bit_width+1.
- Stage 1 (registered): lanes products of prd_width, plus first/last/valid flags.
- Stage 2 (registered): adder tree sums the lanes products into a lane sum.
  - If first: acc <= lane_sum.
  - Else: acc <= acc + lane_sum.
  - If last: o_dp <= final sum (acc_next) and o_valid <= 1.
- Latency: o_valid rises 2 cycles after the edge that accepts the last beat. Throughput is one beat per cycle when not stalled.
- Output handshake: result transfers when o_valid && i_ready.
  - Once transferred with no new result completing that cycle, o_valid <= 0.
  - If a new result completes in the same cycle the old one transfers, o_dp and o_valid update to the new result with no bubble.
- Stall: stall = o_valid && !i_ready.
  - While stall: o_ready=0, and stage 1, stage 2, acc, mode and counter all hold.
  - o_dp and o_valid hold stable until accepted.
  - No data is lost or duplicated.
- o_ready = !stall (combinational).
- Width: no overflow is possible at defaults. Worst case signed is k*2^(2*bit_width-2); worst case unsigned is k*(2^bit_width-1)^2. Both fit in out_width signed. No saturation logic.
- Reset mid-vector discards the partial vector and any in-flight stages. The next accepted beat is treated as first.
- i_valid=0 between beats of a vector is legal; the counter and acc simply wait.

Test Plan:
- Defaults, signed, all a=1, b=1, 4 back-to-back beats, i_ready=1 -> o_valid pulses once, 2 cycles after the 4th accept, with o_dp=32.
- Signed, all a=-128, b=-128 -> o_dp=524288. Then a=-128, b=127 -> o_dp=-520192.
- Unsigned mode on the first beat with i_unsigned toggled on later beats, all a=b=255 -> o_dp=2080800.
- Two vectors back-to-back with i_ready=0 for 10 cycles:
  - Expected: o_ready drops once o_valid is asserted; first result is held stable.
  - After i_ready=1: both results delivered in order, a=i, b=1 patterns giving 496, then b=2 giving 992.
- Gapped input (i_valid low 3 cycles between beats 2 and 3), then i_rst pulsed after beat 2 of the next vector, then a full vector of a=2, b=3 -> only o_dp=192 is output after the reset.
- Config k=8, lanes=8 (beats=1): one vector per cycle with i_ready=1 -> o_valid high continuously, results matching a golden model with a 2-cycle latency.

Source files
------------

// File: rtl/dot_int_acc.sv
// ============================================================================
// Module      : dot_int_acc
// Description : Pipelined integer dot product over k/lanes beats, valid/ready out
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dot_int_acc #(
  parameter int bit_width = 8,
  parameter int k         = 32,
  parameter int lanes     = 8,
  parameter int prd_width = 2*bit_width+1,
  parameter int out_width = prd_width+$clog2(k)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic                          i_unsigned,
  input  logic [bit_width*lanes-1:0]    i_vec_a,
  input  logic [bit_width*lanes-1:0]    i_vec_b,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic signed [out_width-1:0]   o_dp
);

  localparam int beats = k/lanes;
  localparam int CNT_W = (beats > 1) ? $clog2(beats) : 1;

  logic                        w_stall;
  logic                        w_accept;
  logic                        w_first;
  logic                        w_last;
  logic                        w_mode;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_mode;
  logic signed [prd_width-1:0] w_prd [lanes];
  logic signed [prd_width-1:0] r_prd [lanes];
  logic                        r_s1_valid;
  logic                        r_s1_first;
  logic                        r_s1_last;
  logic signed [out_width-1:0] w_lane_sum;
  logic signed [out_width-1:0] r_s2_sum;
  logic                        r_s2_valid;
  logic                        r_s2_first;
  logic                        r_s2_last;
  logic signed [out_width-1:0] r_acc;
  logic signed [out_width-1:0] w_acc_next;
  logic                        r_valid;
  logic signed [out_width-1:0] r_dp;

  assign w_stall  = r_valid & ~i_ready;
  assign o_ready  = ~w_stall;
  assign w_accept = i_valid & ~w_stall;
  assign w_first  = (r_cnt == '0);
  assign w_last   = (r_cnt == CNT_W'(beats-1));
  // The mode of a vector is taken from its first beat; later beats reuse it.
  assign w_mode   = w_first ? i_unsigned : r_mode;
  assign o_valid  = r_valid;
  assign o_dp     = r_dp;

  // Each lane: extend to prd_width (zero or sign by mode), then multiply.
  for (genvar l = 0; l < lanes; l++) begin : g_lane
    logic [bit_width-1:0]        w_a;
    logic [bit_width-1:0]        w_b;
    logic signed [prd_width-1:0] w_ax;
    logic signed [prd_width-1:0] w_bx;
    assign w_a  = i_vec_a[l*bit_width +: bit_width];
    assign w_b  = i_vec_b[l*bit_width +: bit_width];
    assign w_ax = {{(prd_width-bit_width){~w_mode & w_a[bit_width-1]}}, w_a};
    assign w_bx = {{(prd_width-bit_width){~w_mode & w_b[bit_width-1]}}, w_b};
    assign w_prd[l] = w_ax * w_bx;
  end

  always_comb begin
    w_lane_sum = '0;
    for (int l = 0; l < lanes; l++) begin
      w_lane_sum = w_lane_sum + out_width'(r_prd[l]);
    end
  end

  assign w_acc_next = (r_s2_first ? '0 : r_acc) + r_s2_sum;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_mode <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_first) r_mode <= i_unsigned;
    end
  end

  // Stage 1: per-lane products
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      for (int l = 0; l < lanes; l++) r_prd[l] <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_first <= w_first;
        r_s1_last  <= w_last;
        for (int l = 0; l < lanes; l++) r_prd[l] <= w_prd[l];
      end
    end
  end

  // Stage 2: lane sum
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s2_valid <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_sum   <= '0;
    end else if (!w_stall) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_first <= r_s1_first;
        r_s2_last  <= r_s1_last;
        r_s2_sum   <= w_lane_sum;
      end
    end
  end

  // Accumulate and publish; when not stalled the old result is either absent
  // or being accepted this cycle, so valid simply follows the completing beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc   <= '0;
      r_dp    <= '0;
      r_valid <= 1'b0;
    end else if (!w_stall) begin
      r_valid <= r_s2_valid & r_s2_last;
      if (r_s2_valid) begin
        r_acc <= w_acc_next;
        if (r_s2_last) r_dp <= w_acc_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dot_int_acc.sv
// ============================================================================
// Module      : tb_dot_int_acc
// Description : Scoreboard bench for dot_int_acc (default and single-beat configs)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dot_int_acc;

  logic clk;
  logic rst;

  // default configuration: k=32, lanes=8, 4 beats per vector
  logic        v0, u0, i_ready0, o_ready0, o_valid0;
  logic [63:0] a0, b0;
  logic signed [21:0] o_dp0;

  // single-beat configuration: k=8, lanes=8
  logic        v1, u1, i_ready1, o_ready1, o_valid1;
  logic [63:0] a1, b1;
  logic signed [19:0] o_dp1;

  int n_cmp = 0;
  int n_err = 0;
  int n_out0 = 0;
  int n_out1 = 0;
  int q0[$];
  int q1[$];
  int va[32];
  int vb[32];

  dot_int_acc u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_valid(v0), .o_ready(o_ready0),
    .i_unsigned(u0), .i_vec_a(a0), .i_vec_b(b0),
    .o_valid(o_valid0), .i_ready(i_ready0), .o_dp(o_dp0)
  );

  dot_int_acc #(.k(8), .lanes(8)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(v1), .o_ready(o_ready1),
    .i_unsigned(u1), .i_vec_a(a1), .i_vec_b(b1),
    .o_valid(o_valid1), .i_ready(i_ready1), .o_dp(o_dp1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && o_valid0 && i_ready0) begin
      if (q0.size() == 0) check("unexpected_out0", q0.size(), 1);
      else check("dp0", int'(o_dp0), q0.pop_front());
      n_out0++;
    end
    if (!rst && o_valid1 && i_ready1) begin
      if (q1.size() == 0) check("unexpected_out1", q1.size(), 1);
      else check("dp1", int'(o_dp1), q1.pop_front());
      n_out1++;
    end
  end

  // Called on a rising edge; returns on the edge that accepts the beat.
  task automatic beat0(input logic [63:0] a, input logic [63:0] b, input logic u);
    bit ok;
    bit rdy;
    #1;
    v0 = 1'b1; a0 = a; b0 = b; u0 = u;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      rdy = o_ready0;
      @(posedge clk);
      if (rdy) ok = 1'b1;
    end
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic idle0(input int n);
    #1;
    v0 = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_vec0(input bit u, input bit tog, input int gap_at,
                           input int gap_len, input int nbeats);
    int exp;
    int ta;
    int tb;
    logic [63:0] pa;
    logic [63:0] pb;
    exp = 0;
    for (int i = 0; i < 32; i++) exp += va[i] * vb[i];
    for (int j = 0; j < nbeats; j++) begin
      for (int l = 0; l < 8; l++) begin
        ta = va[j*8+l];
        tb = vb[j*8+l];
        pa[l*8 +: 8] = ta[7:0];
        pb[l*8 +: 8] = tb[7:0];
      end
      beat0(pa, pb, (j == 0) ? u : (tog ? ~u : u));
      if (j == 3) q0.push_back(exp);
      if (j == gap_at) idle0(gap_len);
    end
  endtask

  task automatic fill(input int a, input int b);
    for (int i = 0; i < 32; i++) begin
      va[i] = a;
      vb[i] = b;
    end
  endtask

  initial begin
    int x;
    int y;
    int xv;
    int yv;
    int exp;
    rst = 1'b1;
    v0 = 1'b0; u0 = 1'b0; a0 = '0; b0 = '0; i_ready0 = 1'b1;
    v1 = 1'b0; u1 = 1'b0; a1 = '0; b1 = '0; i_ready1 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", o_ready0, 1);
    check("rst_valid", o_valid0, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_dp", int'(o_dp0), 0);
    check("rst_ready_after", o_ready0, 1);
    @(posedge clk);

    // all ones, with latency check on the pulse
    fill(1, 1);
    send_vec0(1'b0, 1'b0, -1, 0, 4);
    #1 v0 = 1'b0;
    @(negedge clk); check("lat_e1", o_valid0, 0);
    @(negedge clk); check("lat_e2", o_valid0, 0);
    @(negedge clk); check("lat_e3", o_valid0, 1);
    @(negedge clk); check("pulse_end", o_valid0, 0);
    @(posedge clk);

    fill(-128, -128);
    send_vec0(1'b0, 1'b0, -1, 0, 4);
    fill(-128, 127);
    send_vec0(1'b0, 1'b0, -1, 0, 4);
    fill(255, 255);
    send_vec0(1'b1, 1'b1, -1, 0, 4);
    idle0(6);

    // two vectors against a stalled consumer
    i_ready0 = 1'b0;
    fork
      begin
        for (int i = 0; i < 32; i++) begin va[i] = i; vb[i] = 1; end
        send_vec0(1'b0, 1'b0, -1, 0, 4);
        for (int i = 0; i < 32; i++) vb[i] = 2;
        send_vec0(1'b0, 1'b0, -1, 0, 4);
        idle0(10);
      end
      begin
        for (int t = 0; t < 100 && !o_valid0; t++) @(negedge clk);
        check("stall_valid", o_valid0, 1);
        repeat (10) begin
          @(negedge clk);
          check("stall_ready", o_ready0, 0);
          check("stall_hold", int'(o_dp0), 496);
        end
        @(posedge clk);
        #1 i_ready0 = 1'b1;
      end
    join

    // gapped vector, then a vector cut short by reset, then a clean one
    fill(3, 1);
    send_vec0(1'b0, 1'b0, 1, 3, 4);
    idle0(6);
    fill(1, 1);
    send_vec0(1'b0, 1'b0, -1, 0, 2);
    #1 v0 = 1'b0;
    rst = 1'b1;
    #2;
    check("midrst_ready", o_ready0, 1);
    check("midrst_valid", o_valid0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    fill(2, 3);
    send_vec0(1'b0, 1'b0, -1, 0, 4);
    idle0(8);
    check("q0_empty", q0.size(), 0);
    check("n_out0", n_out0, 8);

    // single-beat configuration: one vector per cycle
    for (int it = 0; it < 14; it++) begin
      #1;
      v1 = 1'b1;
      u1 = 1'($urandom_range(0, 1));
      exp = 0;
      for (int l = 0; l < 8; l++) begin
        x = int'($urandom_range(0, 255));
        y = int'($urandom_range(0, 255));
        a1[l*8 +: 8] = x[7:0];
        b1[l*8 +: 8] = y[7:0];
        xv = (u1 || x < 128) ? x : x - 256;
        yv = (u1 || y < 128) ? y : y - 256;
        exp += xv * yv;
      end
      q1.push_back(exp);
      @(negedge clk);
      check("rdy1", o_ready1, 1);
      if (it >= 3) check("cont_valid1", o_valid1, 1);
      @(posedge clk);
    end
    #1 v1 = 1'b0;
    repeat (6) @(posedge clk);
    check("q1_empty", q1.size(), 0);
    check("n_out1", n_out1, 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
